l1_dcache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache for the RISC-V core's MEM stage.
- Adds per-line tags, valid and dirty bits, and a miss FSM with a line-wide handshake to backing memory.
- Stalls the pipeline on a miss and keeps byte/half/word load and store semantics with sign/zero extension.
- Exposes hit and miss counters for performance tests.

---
 rtl/l1_dcache_wb_pkg.sv | 32 +++
 rtl/l1_dcache_wb_align.sv | 74 +++++++
 rtl/l1_dcache_wb.sv | 210 +++++++++++++++++++++
 tb/tb_l1_dcache_wb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_dcache_wb_pkg.sv
// Shared types for the L1 write-back data cache: the core's memory-operation
// encoding and the miss-handling FSM states.
package l1_dcache_wb_pkg;

   // Memory operations issued by the MEM stage; any unlisted encoding is idle.
   typedef enum logic [3:0] {
      mem_nop        = 4'd0,
      ld_byte_s      = 4'd1,
      ld_byte_u      = 4'd2,
      ld_half_word_s = 4'd3,
      ld_half_word_u = 4'd4,
      ld_word        = 4'd5,
      str_byte       = 4'd6,
      str_half_word  = 4'd7,
      str_word       = 4'd8
   } mem_operation_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } cache_state_t;

   function automatic logic is_load(mem_operation_t op);
      return op inside {ld_byte_s, ld_byte_u, ld_half_word_s, ld_half_word_u, ld_word};
   endfunction

   function automatic logic is_store(mem_operation_t op);
      return op inside {str_byte, str_half_word, str_word};
   endfunction

endpackage

// File: rtl/l1_dcache_wb_align.sv
// Byte/half/word lane steering: builds the store byte-enable mask and the
// lane-shifted store word, and extracts/extends a load result from a raw word.
// Misaligned offsets are truncated to the access size, never trapped.
module cache_word_align
   import l1_dcache_wb_pkg::*;
#(
   parameter int unsigned WORD_LENGTH = 4
) (
   input  mem_operation_t                     op_i,
   input  logic [$clog2(WORD_LENGTH)-1:0]     byte_no_i,
   input  logic [WORD_LENGTH*8-1:0]           data_i,
   input  logic [WORD_LENGTH*8-1:0]           raw_i,
   output logic [WORD_LENGTH-1:0]             byte_en_o,
   output logic [WORD_LENGTH*8-1:0]           st_word_o,
   output logic [WORD_LENGTH*8-1:0]           ld_data_o
);

   localparam int unsigned DW = WORD_LENGTH * 8;
   localparam int unsigned BW = $clog2(WORD_LENGTH);
   localparam int unsigned SW = $clog2(DW);

   logic [BW-2:0] half_no;
   logic [SW-1:0] byte_sh;
   logic [SW-1:0] half_sh;
   logic [DW-1:0] raw_sh;

   // Halves are selected by the upper offset bits; the lowest bit is dropped.
   assign half_no = byte_no_i[BW-1:1];
   assign byte_sh = {byte_no_i, 3'b000};
   assign half_sh = {half_no, 4'b0000};

   // Decode the operation into store lanes or an extended load value.
   always_comb begin
      byte_en_o = '0;
      st_word_o = '0;
      ld_data_o = '0;
      raw_sh    = '0;
      case (op_i)
         str_byte: begin
            byte_en_o = WORD_LENGTH'(1) << byte_no_i;
            st_word_o = DW'(data_i[7:0]) << byte_sh;
         end
         str_half_word: begin
            byte_en_o = WORD_LENGTH'(3) << {half_no, 1'b0};
            st_word_o = DW'(data_i[15:0]) << half_sh;
         end
         str_word: begin
            byte_en_o = '1;
            st_word_o = data_i;
         end
         ld_byte_s: begin
            raw_sh    = raw_i >> byte_sh;
            ld_data_o = {{(DW - 8){raw_sh[7]}}, raw_sh[7:0]};
         end
         ld_byte_u: begin
            raw_sh    = raw_i >> byte_sh;
            ld_data_o = {{(DW - 8){1'b0}}, raw_sh[7:0]};
         end
         ld_half_word_s: begin
            raw_sh    = raw_i >> half_sh;
            ld_data_o = {{(DW - 16){raw_sh[15]}}, raw_sh[15:0]};
         end
         ld_half_word_u: begin
            raw_sh    = raw_i >> half_sh;
            ld_data_o = {{(DW - 16){1'b0}}, raw_sh[15:0]};
         end
         ld_word: begin
            ld_data_o = raw_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/l1_dcache_wb.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Hits complete combinationally; misses stall the core while a line-wide
// writeback (if the victim is dirty) and refill run against backing memory.
module l1_dcache_wb
   import l1_dcache_wb_pkg::*;
#(
   parameter int unsigned WORD_LENGTH   = 4,
   parameter int unsigned CACHE_WIDTH   = 4,
   parameter int unsigned DEPTH         = 64,
   parameter int unsigned ADDRESS_WIDTH = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  mem_operation_t                       mem_operation,
   input  logic [ADDRESS_WIDTH-1:0]             address,
   input  logic [WORD_LENGTH*8-1:0]             data_in,
   output logic [WORD_LENGTH*8-1:0]             data_out,
   output logic                                 stall,
   output logic                                 mem_req,
   output logic                                 mem_we,
   output logic [ADDRESS_WIDTH-1:0]             mem_address,
   output logic [CACHE_WIDTH*WORD_LENGTH*8-1:0] mem_wdata,
   input  logic [CACHE_WIDTH*WORD_LENGTH*8-1:0] mem_rdata,
   input  logic                                 mem_ready,
   output logic [31:0]                          hit_count,
   output logic [31:0]                          miss_count
);

   localparam int unsigned DW     = WORD_LENGTH * 8;
   localparam int unsigned SW     = $clog2(DW);
   localparam int unsigned LINE_W = CACHE_WIDTH * DW;
   localparam int unsigned OFF_W  = $clog2(WORD_LENGTH);
   localparam int unsigned WN_W   = $clog2(CACHE_WIDTH);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned LOW_W  = OFF_W + WN_W;
   localparam int unsigned TAG_W  = ADDRESS_WIDTH - IDX_W - LOW_W;

   // Address fields: {tag, index, word_no, byte_no}.
   logic [OFF_W-1:0]      byte_no;
   logic [WN_W-1:0]       word_no;
   logic [IDX_W-1:0]      index;
   logic [TAG_W-1:0]      tag;
   logic [WN_W+SW-1:0]    word_base;

   // Storage; tags and data are deliberately left unreset.
   logic [TAG_W-1:0]      tag_q  [DEPTH];
   logic [LINE_W-1:0]     line_q [DEPTH];
   logic [DEPTH-1:0]      valid_q;
   logic [DEPTH-1:0]      dirty_q;

   cache_state_t          state_q;
   logic [TAG_W-1:0]      miss_tag_q;
   logic [IDX_W-1:0]      miss_idx_q;
   logic                  refilled_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [ADDRESS_WIDTH-1:0] mem_address_q;
   logic [LINE_W-1:0]     mem_wdata_q;
   logic [31:0]           hit_count_q;
   logic [31:0]           miss_count_q;

   logic [LINE_W-1:0]     cur_line;
   logic [LINE_W-1:0]     store_line;
   logic [DW-1:0]         raw_word;
   logic [DW-1:0]         st_word;
   logic [DW-1:0]         ld_data;
   logic [WORD_LENGTH-1:0] byte_en;
   logic                  is_ld;
   logic                  is_st;
   logic                  access;
   logic                  hit;
   logic                  idle_hit;
   logic                  idle_miss;
   logic                  victim_dirty;

   assign byte_no   = address[OFF_W-1:0];
   assign word_no   = address[LOW_W-1:OFF_W];
   assign index     = address[LOW_W+IDX_W-1:LOW_W];
   assign tag       = address[ADDRESS_WIDTH-1:LOW_W+IDX_W];
   assign word_base = {word_no, {SW{1'b0}}};

   assign cur_line  = line_q[index];
   assign raw_word  = cur_line[word_base +: DW];

   assign is_ld     = is_load(mem_operation);
   assign is_st     = is_store(mem_operation);
   assign access    = is_ld | is_st;
   assign hit       = valid_q[index] && (tag_q[index] == tag);
   assign idle_hit  = (state_q == IDLE) && access && hit;
   assign idle_miss = (state_q == IDLE) && access && !hit;
   assign victim_dirty = valid_q[index] && dirty_q[index];

   assign stall       = (state_q != IDLE) || idle_miss;
   assign data_out    = (idle_hit && is_ld) ? ld_data : '0;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign hit_count   = hit_count_q;
   assign miss_count  = miss_count_q;

   cache_word_align #(
      .WORD_LENGTH (WORD_LENGTH)
   ) u_align (
      .op_i      (mem_operation),
      .byte_no_i (byte_no),
      .data_i    (data_in),
      .raw_i     (raw_word),
      .byte_en_o (byte_en),
      .st_word_o (st_word),
      .ld_data_o (ld_data)
   );

   // Merge the enabled store lanes into the currently indexed line.
   always_comb begin
      store_line = cur_line;
      for (int b = 0; b < WORD_LENGTH; b++) begin
         if (byte_en[b]) begin
            store_line[word_base + b * 8 +: 8] = st_word[b * 8 +: 8];
         end
      end
   end

   // Tag/data array writes: refill on the closing handshake, store merge on a hit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == REFILL && mem_ready) begin
            line_q[miss_idx_q] <= mem_rdata;
            tag_q[miss_idx_q]  <= miss_tag_q;
         end else if (idle_hit && is_st) begin
            line_q[index] <= store_line;
         end
      end
   end

   // Miss FSM with registered memory-side outputs, line state bits and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         valid_q       <= '0;
         dirty_q       <= '0;
         miss_tag_q    <= '0;
         miss_idx_q    <= '0;
         refilled_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         hit_count_q   <= '0;
         miss_count_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               refilled_q <= 1'b0;
               if (idle_hit) begin
                  // The held request completing after a refill is not a new hit.
                  if (!refilled_q) begin
                     hit_count_q <= hit_count_q + 32'd1;
                  end
                  if (is_st) begin
                     dirty_q[index] <= 1'b1;
                  end
               end else if (idle_miss) begin
                  miss_count_q <= miss_count_q + 32'd1;
                  miss_tag_q   <= tag;
                  miss_idx_q   <= index;
                  mem_req_q    <= 1'b1;
                  if (victim_dirty) begin
                     state_q       <= WRITEBACK;
                     mem_we_q      <= 1'b1;
                     mem_address_q <= {tag_q[index], index, {LOW_W{1'b0}}};
                     mem_wdata_q   <= cur_line;
                  end else begin
                     state_q       <= REFILL;
                     mem_we_q      <= 1'b0;
                     mem_address_q <= {tag, index, {LOW_W{1'b0}}};
                     mem_wdata_q   <= '0;
                  end
               end
            end
            WRITEBACK: begin
               // mem_req stays high; only the direction and address switch over.
               if (mem_ready) begin
                  state_q       <= REFILL;
                  mem_we_q      <= 1'b0;
                  mem_address_q <= {miss_tag_q, miss_idx_q, {LOW_W{1'b0}}};
                  mem_wdata_q   <= '0;
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  state_q             <= IDLE;
                  valid_q[miss_idx_q] <= 1'b1;
                  dirty_q[miss_idx_q] <= 1'b0;
                  refilled_q          <= 1'b1;
                  mem_req_q           <= 1'b0;
                  mem_we_q            <= 1'b0;
                  mem_address_q       <= '0;
                  mem_wdata_q         <= '0;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_dcache_wb.sv
// Self-checking bench for l1_dcache_wb: a latency-programmable backing memory
// model plus scenario tasks; load results are queued when issued and popped
// when the cache completes the access.
module tb_l1_dcache_wb;
   import l1_dcache_wb_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   mem_operation_t mem_operation;
   logic [31:0]    address;
   logic [31:0]    data_in;
   logic [31:0]    data_out;
   logic           stall;
   logic           mem_req;
   logic           mem_we;
   logic [31:0]    mem_address;
   logic [127:0]   mem_wdata;
   logic [127:0]   mem_rdata;
   logic           mem_ready;
   logic [31:0]    hit_count;
   logic [31:0]    miss_count;

   int checks = 0;
   int errors = 0;
   int lat = 3;

   logic [31:0]  exp_q[$];
   logic [31:0]  hs_addr[$];
   logic         hs_we[$];
   logic [127:0] hs_data[$];
   logic [127:0] mem_model [logic [31:0]];

   localparam logic [127:0] VICTIM_LINE =
      {32'h5678_6666, 32'h3333_4444, 32'h1111_2222, 32'h8001_7FFF};

   l1_dcache_wb u_dut (
      .clk           (clk),
      .rst           (rst),
      .mem_operation (mem_operation),
      .address       (address),
      .data_in       (data_in),
      .data_out      (data_out),
      .stall         (stall),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_address   (mem_address),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   always #5 clk = ~clk;

   // Default contents for lines never written: word w = (line + 4w) ^ C0DE0000.
   function automatic logic [127:0] pattern(input logic [31:0] a);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = (a + 32'(w * 4)) ^ 32'hC0DE_0000;
      return l;
   endfunction

   // Backing memory: raises mem_ready in the lat-th cycle of each request.
   initial begin
      int cnt;
      cnt = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      mem_model[32'h100] = {32'h5555_6666, 32'h3333_4444, 32'h1111_2222, 32'hDEAD_BEEF};
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = 0;
         end
         if (mem_req) begin
            cnt++;
            if (cnt >= lat) begin
               mem_ready = 1'b1;
               hs_addr.push_back(mem_address);
               hs_we.push_back(mem_we);
               hs_data.push_back(mem_wdata);
               if (mem_we) mem_model[mem_address] = mem_wdata;
               else mem_rdata = mem_model.exists(mem_address) ? mem_model[mem_address]
                                                              : pattern(mem_address);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // Issue one request at posedge+1, wait (bounded) for completion, score loads.
   task automatic access(input string nm, input mem_operation_t op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, output int stalls);
      logic [31:0] want;
      logic        ld;
      want = '0;
      ld = is_load(op);
      if (ld) exp_q.push_back(exp);
      mem_operation = op;
      address = addr;
      data_in = wdata;
      stalls = 0;
      @(negedge clk);
      while (stall && stalls < 500) begin
         stalls++;
         @(negedge clk);
      end
      checks++;
      if (ld) want = exp_q.pop_front();
      if (stall) begin
         errors++;
         $display("FAIL %s: still stalled after %0d cycles", nm, stalls);
      end else if (ld && data_out !== want) begin
         errors++;
         $display("FAIL %s: data_out got %h want %h", nm, data_out, want);
      end
      @(posedge clk);
      #1;
      mem_operation = mem_nop;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || data_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_core: stall=%b data_out=%h want 0/0", stall, data_out);
      end
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_address !== 32'h0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h want all 0",
                  mem_req, mem_we, mem_address, mem_wdata);
      end
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_miss();
      int st;
      int n0;
      lat = 3;
      n0 = hs_addr.size();
      access("miss_ld_word", ld_word, 32'h100, 32'h0, 32'hDEAD_BEEF, st);
      checks++;
      if (st !== 4) begin
         errors++;
         $display("FAIL miss_stall_cycles: got %0d want 4", st);
      end
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd1) begin
         errors++;
         $display("FAIL miss_counters: hit=%0d miss=%0d want 0/1", hit_count, miss_count);
      end
      checks++;
      if (hs_addr.size() != n0 + 1 || hs_addr[n0] !== 32'h100 || hs_we[n0] !== 1'b0) begin
         errors++;
         $display("FAIL miss_handshake: count=%0d want %0d, first addr/we must be 100/0",
                  hs_addr.size(), n0 + 1);
      end
   endtask

   task automatic test_byte_access();
      int st;
      access("str_byte_hit", str_byte, 32'h101, 32'h1234_5680, 32'h0, st);
      checks++;
      if (st !== 0) begin
         errors++;
         $display("FAIL str_byte_stall: got %0d want 0", st);
      end
      access("ld_byte_s", ld_byte_s, 32'h101, 32'h0, 32'hFFFF_FF80, st);
      checks++;
      if (hit_count !== 32'd2) begin
         errors++;
         $display("FAIL hit_after_pair: got %0d want 2", hit_count);
      end
      access("ld_byte_u", ld_byte_u, 32'h101, 32'h0, 32'h0000_0080, st);
      access("ld_byte_u_b0", ld_byte_u, 32'h100, 32'h0, 32'h0000_00EF, st);
      access("ld_byte_s_b3", ld_byte_s, 32'h103, 32'h0, 32'hFFFF_FFDE, st);
      checks++;
      if (hit_count !== 32'd5) begin
         errors++;
         $display("FAIL hit_after_bytes: got %0d want 5", hit_count);
      end
   endtask

   task automatic test_half_access();
      int st;
      access("str_word", str_word, 32'h100, 32'h8001_7FFF, 32'h0, st);
      access("ld_half_s_hi", ld_half_word_s, 32'h102, 32'h0, 32'hFFFF_8001, st);
      access("ld_half_s_lo", ld_half_word_s, 32'h100, 32'h0, 32'h0000_7FFF, st);
      access("ld_half_u_mis", ld_half_word_u, 32'h103, 32'h0, 32'h0000_8001, st);
      access("ld_half_u_lo", ld_half_word_u, 32'h101, 32'h0, 32'h0000_7FFF, st);
      access("str_half_hi", str_half_word, 32'h10E, 32'h1234_5678, 32'h0, st);
      access("ld_word_w3", ld_word, 32'h10C, 32'h0, 32'h5678_6666, st);
      access("ld_word_mis", ld_word, 32'h10D, 32'h0, 32'h5678_6666, st);
      checks++;
      if (hit_count !== 32'd13 || miss_count !== 32'd1) begin
         errors++;
         $display("FAIL half_counters: hit=%0d miss=%0d want 13/1", hit_count, miss_count);
      end
   endtask

   task automatic test_dirty_evict();
      int st;
      int n0;
      lat = 2;
      n0 = hs_addr.size();
      access("evict_ld", ld_word, 32'h508, 32'h0, 32'hC0DE_0508, st);
      checks++;
      if (st !== 5) begin
         errors++;
         $display("FAIL evict_stall_cycles: got %0d want 5", st);
      end
      checks++;
      if (hs_addr.size() != n0 + 2) begin
         errors++;
         $display("FAIL evict_hs_count: got %0d want %0d", hs_addr.size(), n0 + 2);
      end else begin
         checks++;
         if (hs_addr[n0] !== 32'h100 || hs_we[n0] !== 1'b1 || hs_data[n0] !== VICTIM_LINE) begin
            errors++;
            $display("FAIL evict_writeback: addr=%h we=%b data=%h want 100/1/%h",
                     hs_addr[n0], hs_we[n0], hs_data[n0], VICTIM_LINE);
         end
         checks++;
         if (hs_addr[n0+1] !== 32'h500 || hs_we[n0+1] !== 1'b0) begin
            errors++;
            $display("FAIL evict_refill: addr=%h we=%b want 500/0", hs_addr[n0+1], hs_we[n0+1]);
         end
      end
      checks++;
      if (hit_count !== 32'd13 || miss_count !== 32'd2) begin
         errors++;
         $display("FAIL evict_counters: hit=%0d miss=%0d want 13/2", hit_count, miss_count);
      end
      access("evict_hit", ld_word, 32'h500, 32'h0, 32'hC0DE_0500, st);
      access("reload_old", ld_word, 32'h100, 32'h0, 32'h8001_7FFF, st);
      checks++;
      if (st !== 3 || hs_addr.size() != n0 + 3) begin
         errors++;
         $display("FAIL reload_clean: stalls=%0d hs=%0d want 3/%0d", st, hs_addr.size(), n0 + 3);
      end
      checks++;
      if (hit_count !== 32'd14 || miss_count !== 32'd3) begin
         errors++;
         $display("FAIL reload_counters: hit=%0d miss=%0d want 14/3", hit_count, miss_count);
      end
   endtask

   task automatic test_mem_stall();
      int st;
      int wait_cnt;
      logic [31:0] want;
      lat = 11;
      exp_q.push_back(32'hC0DE_2000);
      mem_operation = ld_word;
      address = 32'h2000;
      data_in = 32'h0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL stall_miss_cycle: stall=%b req=%b want 1/0", stall, mem_req);
      end
      st = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (stall) st++;
         checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_address !== 32'h2000 ||
             mem_wdata !== '0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL hold_cycle_%0d: req=%b we=%b addr=%h stall=%b want 1/0/2000/1",
                     i, mem_req, mem_we, mem_address, stall);
         end
      end
      wait_cnt = 0;
      @(negedge clk);
      while (stall && wait_cnt < 100) begin
         st++;
         wait_cnt++;
         @(negedge clk);
      end
      want = exp_q.pop_front();
      checks++;
      if (stall !== 1'b0 || data_out !== want) begin
         errors++;
         $display("FAIL hold_result: stall=%b data_out=%h want 0/%h", stall, data_out, want);
      end
      @(posedge clk);
      #1;
      mem_operation = mem_nop;
      checks++;
      if (st !== 12 || miss_count !== 32'd4) begin
         errors++;
         $display("FAIL hold_totals: stalls=%0d miss=%0d want 12/4", st, miss_count);
      end
   endtask

   task automatic test_reset_refill();
      int st;
      lat = 20;
      mem_operation = ld_word;
      address = 32'h3000;
      data_in = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_req: got %b want 1", mem_req);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_operation = mem_nop;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_address !== 32'h0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL rst_abort: req=%b we=%b addr=%h stall=%b want 0/0/0/0",
                  mem_req, mem_we, mem_address, stall);
      end
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_counters: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
      end
      @(posedge clk);
      #1;
      lat = 2;
      access("reissue", ld_word, 32'h3000, 32'h0, 32'hC0DE_3000, st);
      checks++;
      if (st !== 3 || miss_count !== 32'd1) begin
         errors++;
         $display("FAIL reissue_miss: stalls=%0d miss=%0d want 3/1", st, miss_count);
      end
      access("post_rst_wb", ld_word, 32'h100, 32'h0, 32'h8001_7FFF, st);
      checks++;
      if (st !== 3 || miss_count !== 32'd2 || hit_count !== 32'd0) begin
         errors++;
         $display("FAIL post_rst_counts: stalls=%0d miss=%0d hit=%0d want 3/2/0",
                  st, miss_count, hit_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      mem_operation = mem_nop;
      address = 32'h0;
      data_in = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_clean_miss();
      test_byte_access();
      test_half_access();
      test_dirty_evict();
      test_mem_stall();
      test_reset_refill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
